// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the EXU/LSU write-back stage and the register-file
// write arbiter. The bypass read ports exist only when WB_ARB_BYPASS_EN is
// defined.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            exu_valid;
    logic            exu_ready;
    logic [4:0]      exu_rd;
    logic [XLEN-1:0] exu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

`ifdef WB_ARB_BYPASS_EN
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
`endif

    // Write-back sources and decode side
    modport master (
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  exu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata
`ifdef WB_ARB_BYPASS_EN
        ,
        output rs1_addr, rs2_addr,
        input  rs1_hit, rs2_hit, rs1_data, rs2_data
`endif
    );

    // Arbiter side
    modport slave (
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output exu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata
`ifdef WB_ARB_BYPASS_EN
        ,
        input  rs1_addr, rs2_addr,
        output rs1_hit, rs2_hit, rs1_data, rs2_data
`endif
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for the EXU and LSU write-back sources.
// Each source owns a one-entry buffer; a fixed-priority arbiter (LSU first)
// with a starvation guard for the EXU drives a registered write port.
// Optional feature: WB_ARB_BYPASS_EN adds combinational bypass read ports
// that expose the write currently presented to the register file.
module regfile_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave wb
);
    localparam logic [2:0] C_STARVE_LIM = 3'(STARVE_MAX);

    logic            r_exu_full;
    logic [4:0]      r_exu_rd;
    logic [XLEN-1:0] r_exu_data;
    logic            r_lsu_full;
    logic [4:0]      r_lsu_rd;
    logic [XLEN-1:0] r_lsu_data;
    logic [2:0]      r_starve_cnt;
    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic w_grant_exu;
    logic w_grant_lsu;
    logic w_exu_ready;
    logic w_lsu_ready;
    logic w_exu_load;
    logic w_lsu_load;

    // LSU wins a collision unless the EXU has already lost STARVE_MAX times
    assign w_grant_exu = r_exu_full && (!r_lsu_full || (r_starve_cnt == C_STARVE_LIM));
    assign w_grant_lsu = r_lsu_full && !w_grant_exu;

    // Ready is a function of buffer state only, never of the valid inputs
    assign w_exu_ready = !rst && (!r_exu_full || w_grant_exu);
    assign w_lsu_ready = !rst && (!r_lsu_full || w_grant_lsu);

    // Writes to x0 complete the handshake but are dropped here
    assign w_exu_load = wb.exu_valid && w_exu_ready && (wb.exu_rd != 5'd0);
    assign w_lsu_load = wb.lsu_valid && w_lsu_ready && (wb.lsu_rd != 5'd0);

    assign wb.exu_ready = w_exu_ready;
    assign wb.lsu_ready = w_lsu_ready;
    assign wb.rf_wen    = r_wen;
    assign wb.rf_waddr  = r_waddr;
    assign wb.rf_wdata  = r_wdata;

    // EXU holding buffer: a reload in the granted cycle keeps it full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exu_full <= 1'b0;
            r_exu_rd   <= 5'd0;
            r_exu_data <= '0;
        end else if (w_exu_load) begin
            r_exu_full <= 1'b1;
            r_exu_rd   <= wb.exu_rd;
            r_exu_data <= wb.exu_data;
        end else if (w_grant_exu) begin
            r_exu_full <= 1'b0;
        end
    end

    // LSU holding buffer, same policy as the EXU buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_full <= 1'b0;
            r_lsu_rd   <= 5'd0;
            r_lsu_data <= '0;
        end else if (w_lsu_load) begin
            r_lsu_full <= 1'b1;
            r_lsu_rd   <= wb.lsu_rd;
            r_lsu_data <= wb.lsu_data;
        end else if (w_grant_lsu) begin
            r_lsu_full <= 1'b0;
        end
    end

    // Count consecutive EXU losses, saturating at the forcing threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant_exu || !r_exu_full) begin
            r_starve_cnt <= 3'd0;
        end else if (w_grant_lsu && (r_starve_cnt != C_STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    // Registered write port; address and data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= '0;
        end else if (w_grant_exu) begin
            r_wen   <= 1'b1;
            r_waddr <= r_exu_rd;
            r_wdata <= r_exu_data;
        end else if (w_grant_lsu) begin
            r_wen   <= 1'b1;
            r_waddr <= r_lsu_rd;
            r_wdata <= r_lsu_data;
        end else begin
            r_wen   <= 1'b0;
        end
    end

`ifdef WB_ARB_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Decode can see the value being written to the register file this cycle
    assign w_rs1_hit   = r_wen && (r_waddr == wb.rs1_addr) && (wb.rs1_addr != 5'd0);
    assign w_rs2_hit   = r_wen && (r_waddr == wb.rs2_addr) && (wb.rs2_addr != 5'd0);
    assign wb.rs1_hit  = w_rs1_hit;
    assign wb.rs2_hit  = w_rs2_hit;
    assign wb.rs1_data = w_rs1_hit ? r_wdata : '0;
    assign wb.rs2_data = w_rs2_hit ? r_wdata : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table covering
// reset release, x0 drop, collision and back-to-back streaming, followed by
// hand-written starvation, mid-operation reset and bypass sequences.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(64)) wb();
    regfile_wb_arbiter #(.XLEN(64), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [63:0] ed;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        er;
        logic        lr;
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
    } vec_t;

    vec_t vecs[23];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t v(logic ev, logic [4:0] erd, logic [63:0] ed,
                               logic lv, logic [4:0] lrd, logic [63:0] ld,
                               logic er, logic lr, logic wen, logic [4:0] wa,
                               logic [63:0] wd);
        vec_t r;
        r.ev = ev; r.erd = erd; r.ed = ed;
        r.lv = lv; r.lrd = lrd; r.ld = ld;
        r.er = er; r.lr = lr; r.wen = wen; r.wa = wa; r.wd = wd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        wb.exu_valid = ev;
        wb.exu_rd    = erd;
        wb.exu_data  = ed;
        wb.lsu_valid = lv;
        wb.lsu_rd    = lrd;
        wb.lsu_data  = ld;
    endtask

    initial begin
        logic [4:0]  got_a[6];
        logic [63:0] got_d[6];
        logic [4:0]  exp_a[6];
        int          wcnt;
        int          lrd;
        logic        lrdy;

        //               ev    erd    ed          lv    lrd    ld           er    lr    wen   wa     wd
        vecs[0]  = v(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        vecs[1]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd0, 64'h0);
        vecs[2]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd5, 64'h1234);
        vecs[3]  = v(1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 64'hdead, 1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[4]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[5]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[6]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[7]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[8]  = v(1'b1, 5'd3, 64'hA,    1'b1, 5'd4, 64'hB,    1'b1, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[9]  = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 1'b1, 1'b0, 5'd5, 64'h1234);
        vecs[10] = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd4, 64'hB);
        vecs[11] = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd3, 64'hA);
        vecs[12] = v(1'b1, 5'd1, 64'h101,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd3, 64'hA);
        vecs[13] = v(1'b1, 5'd2, 64'h102,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd3, 64'hA);
        vecs[14] = v(1'b1, 5'd3, 64'h103,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd1, 64'h101);
        vecs[15] = v(1'b1, 5'd4, 64'h104,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd2, 64'h102);
        vecs[16] = v(1'b1, 5'd5, 64'h105,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd3, 64'h103);
        vecs[17] = v(1'b1, 5'd6, 64'h106,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd4, 64'h104);
        vecs[18] = v(1'b1, 5'd7, 64'h107,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd5, 64'h105);
        vecs[19] = v(1'b1, 5'd8, 64'h108,  1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd6, 64'h106);
        vecs[20] = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd7, 64'h107);
        vecs[21] = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b1, 5'd8, 64'h108);
        vecs[22] = v(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 1'b0, 5'd8, 64'h108);

        // Reset held for 3 cycles with the EXU requesting
        rst = 1'b1;
        drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
`ifdef WB_ARB_BYPASS_EN
        wb.rs1_addr = 5'd0;
        wb.rs2_addr = 5'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #4;
            chk("rst_exu_ready", 64'(wb.exu_ready), 64'd0);
            chk("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
            chk("rst_rf_wen",    64'(wb.rf_wen),    64'd0);
        end
        chk("rst_rf_waddr", 64'(wb.rf_waddr), 64'd0);
        chk("rst_rf_wdata", wb.rf_wdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven per-cycle vectors
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].ev, vecs[i].erd, vecs[i].ed, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            #4;
            chk($sformatf("vec%0d_exu_ready", i), 64'(wb.exu_ready), 64'(vecs[i].er));
            chk($sformatf("vec%0d_lsu_ready", i), 64'(wb.lsu_ready), 64'(vecs[i].lr));
            chk($sformatf("vec%0d_rf_wen", i),    64'(wb.rf_wen),    64'(vecs[i].wen));
            chk($sformatf("vec%0d_rf_waddr", i),  64'(wb.rf_waddr),  64'(vecs[i].wa));
            chk($sformatf("vec%0d_rf_wdata", i),  wb.rf_wdata,       vecs[i].wd);
            @(posedge clk); #1;
        end

        // Starvation: EXU holds rd=7 while the LSU streams every cycle
        exp_a[0] = 5'd10; exp_a[1] = 5'd11; exp_a[2] = 5'd12;
        exp_a[3] = 5'd13; exp_a[4] = 5'd7;  exp_a[5] = 5'd14;
        for (int k = 0; k < 6; k++) begin
            got_a[k] = 5'd0;
            got_d[k] = 64'd0;
        end
        wcnt = 0;
        lrd  = 10;
        for (int c = 0; c < 14; c++) begin
            drive((c == 0), 5'd7, 64'h77, 1'b1, 5'(lrd), 64'h1000 + 64'(lrd));
            #4;
            if (c == 0) chk("starve_exu_handshake", 64'(wb.exu_ready), 64'd1);
            lrdy = wb.lsu_ready;
            if (wb.rf_wen && wcnt < 6) begin
                got_a[wcnt] = wb.rf_waddr;
                got_d[wcnt] = wb.rf_wdata;
                if (wb.rf_waddr == 5'd7)
                    chk("starve_cnt_cleared", 64'(dut.r_starve_cnt), 64'd0);
                wcnt++;
            end
            @(posedge clk); #1;
            if (lrdy) lrd++;
        end
        chk("starve_write_count", 64'(wcnt >= 6), 64'd1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("starve_w%0d_addr", k), 64'(got_a[k]), 64'(exp_a[k]));
            chk($sformatf("starve_w%0d_data", k), got_d[k],
                (exp_a[k] == 5'd7) ? 64'h77 : 64'h1000 + 64'(exp_a[k]));
        end
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-operation discards a buffered write
        drive(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'h0);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("midrst_rf_wen_c%0d", c), 64'(wb.rf_wen), 64'd0);
            @(posedge clk); #1;
        end
        chk("midrst_rf_waddr", 64'(wb.rf_waddr), 64'd0);

`ifdef WB_ARB_BYPASS_EN
        // Bypass hit while rd=9 is on the write port
        drive(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'h0);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        @(posedge clk); #1;
        wb.rs1_addr = 5'd9;
        wb.rs2_addr = 5'd0;
        #3;
        chk("byp_rf_wen",   64'(wb.rf_wen),   64'd1);
        chk("byp_rf_waddr", 64'(wb.rf_waddr), 64'd9);
        chk("byp_rs1_hit",  64'(wb.rs1_hit),  64'd1);
        chk("byp_rs1_data", wb.rs1_data,      64'h55);
        chk("byp_rs2_hit",  64'(wb.rs2_hit),  64'd0);
        chk("byp_rs2_data", wb.rs2_data,      64'd0);
        @(posedge clk); #4;
        chk("byp_rs1_idle_hit",  64'(wb.rs1_hit), 64'd0);
        chk("byp_rs1_idle_data", wb.rs1_data,     64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single general-purpose register-file write port of the NPC core between two write-back sources: the EXU (ALU/CSR results) and the LSU (load data).
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A fixed-priority arbiter with a starvation guard selects one buffered write per cycle and drives a registered write port into the register file.
- The block sits between the EXU/LSU write-back stage and the register file whose 32×64-bit contents are exported to the simulation environment.

## Interface
Parameters:
- XLEN, 64, data width of a register write.
- STARVE_MAX, 4, consecutive EXU losses tolerated before the EXU is forced ahead of the LSU (1..7).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- exu_valid  in  1  EXU write request present.
- exu_ready  out  1  EXU request accepted this cycle when high together with exu_valid.
- exu_rd  in  5  EXU destination register.
- exu_data  in  XLEN  EXU write data.
- lsu_valid / lsu_ready / lsu_rd / lsu_data  have the same direction and width as the EXU ports and serve the LSU.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- Bypass ports, present only with WB_ARB_BYPASS_EN:
  - rs1_addr  in  5  read address.
  - rs2_addr  in  5  read address.
  - rs1_hit  out  1  bypass hit flag for rs1.
  - rs2_hit  out  1  bypass hit flag for rs2.
  - rs1_data  out  XLEN  bypass data for rs1.
  - rs2_data  out  XLEN  bypass data for rs2.

## Operation
Reset state:
- Both buffers empty.
- rf_wen=0, rf_waddr=0, rf_wdata=0.
- Starvation counter starve_cnt=0.
- exu_ready=lsu_ready=0 while rst=1.
- Reset mid-operation discards buffered writes without writing them.

Handshake and buffering:
- Per source: src_ready = !buf_full || grant_src. Ready depends only on internal state, never on src_valid.
- Transfer occurs on valid&&ready at the clock edge. The buffer loads {rd, data} and becomes full.
- A transfer with rd==0 completes the handshake but does not load the buffer; x0 is never written.
- Simultaneous drain (grant) and load in the same cycle keeps the buffer full with the new entry. This sustains one write per cycle per source.

Arbitration, evaluated combinationally each cycle from buffer state:
- Only one buffer full: that source is granted.
- Both full and starve_cnt==STARVE_MAX: EXU is granted.
- Both full otherwise: LSU is granted.
- Neither full: no grant.

Starvation counter (3-bit, saturating at STARVE_MAX):
- +1 when the EXU buffer is full and the LSU is granted.
- Cleared when the EXU is granted or the EXU buffer is empty.

Output register:
- On a grant: rf_wen←1, and rf_waddr/rf_wdata←the granted entry; the granted buffer empties unless reloaded.
- With no grant: rf_wen←0, and rf_waddr/rf_wdata hold their previous values.

Write ordering:
- Writes from the same source reach the register file in acceptance order.
- Cross-source ordering to the same rd is not guaranteed. The issue logic must avoid WAW across sources.

## Timing
- Latency, uncontended: handshake in cycle T → rf_wen=1 in cycle T+2.
- Contended loser: one extra cycle per lost arbitration. The worst case for the EXU is STARVE_MAX extra cycles while the LSU stays saturated.
- Throughput: one register write per cycle total.
- No combinational path from any *_valid to any *_ready.
- Bypass outputs (with the macro) are combinational from rs*_addr and the output register.

## Configuration
WB_ARB_BYPASS_EN:
- Defined:
  - rs*_hit = rf_wen && (rf_waddr==rs*_addr) && (rs*_addr!=0).
  - rs*_data = rf_wdata when hit, else 0.
  - This lets decode read the value being written this cycle.
- Undefined: the rs*_ ports and the bypass logic are absent. Arbitration, latency and all other behaviour are unchanged.

## Test plan
- Reset: hold rst=1 for 3 cycles with exu_valid=1 → exu_ready=0 and rf_wen=0 throughout. After release, the first request exu_rd=5, exu_data=0x1234 gives rf_wen=1, rf_waddr=5, rf_wdata=0x1234 exactly 2 cycles after the handshake.
- x0 drop: lsu_valid=1 with lsu_rd=0, lsu_data=0xdead → handshake completes, and rf_wen stays 0 for the next 4 cycles.
- Collision: EXU (rd=3, 0xA) and LSU (rd=4, 0xB) handshake in the same cycle → LSU write (4, 0xB) at T+2, EXU write (3, 0xA) at T+3.
- Starvation: LSU streams valid writes every cycle while the EXU holds one request (rd=7) → EXU granted after exactly STARVE_MAX=4 LSU grants, then starve_cnt returns to 0.
- Back-to-back: EXU presents rd=1..8 on consecutive cycles with the LSU idle → exu_ready stays 1, and eight consecutive rf_wen=1 cycles occur in order.
- Bypass (macro on): rs1_addr=9 during the cycle rf_waddr=9, rf_wen=1, rf_wdata=0x55 → rs1_hit=1, rs1_data=0x55. With rs2_addr=0 → rs2_hit=0.
